// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer for the multi-cycle CPU.
// Owns the program counter, runs the imem request/ready handshake, pulses the
// IR load enable in the ready cycle, then hands off to the execute controller
// and waits for exec_done. Absorbs wait states, redirects and fetch faults.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   run              permits starting new fetches (level)
//   imem_req/addr    fetch request and address (addr always equals pc_out)
//   imem_ready       memory data valid this cycle
//   ir_ena           IR load enable, combinational, high in the ready cycle
//   pc_out           current PC
//   exec_start       one-cycle pulse: IR holds a new instruction
//   exec_done        execute controller finished
//   redirect_valid/pc branch/jump target, sampled with exec_done
//   busy, err, err_code  status; err sticky until rst
//   instr_count      instructions loaded into the IR (wraps)
module ifetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000,
  parameter logic [15:0] TIMEOUT  = 16'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        ir_ena,
  output logic [31:0] pc_out,
  output logic        exec_start,
  input  logic        exec_done,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] instr_count
);

  localparam int unsigned AW = 32;
  localparam int unsigned WW = 16;
  localparam int unsigned CW = 32;

  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_ERR} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [1:0]      code_q, code_d;
  logic            exec_start_q, exec_start_d;
  logic            timeout_hit_c;
  logic            misaligned_c;

  // Expiry is judged on the count before this edge; ready is checked first so
  // it always wins over a simultaneous expiry.
  always_comb begin
    timeout_hit_c = (TIMEOUT != WW'(0)) && (wait_q == WW'(TIMEOUT - WW'(1)));
    misaligned_c  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready)         state_d = S_EXEC;
        else if (timeout_hit_c) state_d = S_ERR;
      end
      S_EXEC: begin
        if (exec_done) begin
          if (misaligned_c) state_d = S_ERR;
          else              state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / registered output next values
  always_comb begin
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    code_d       = code_q;
    exec_start_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          pc_d         = pc_q + AW'(4);
          cnt_d        = cnt_q + CW'(1);
          wait_d       = '0;
          exec_start_d = 1'b1;
        end else if (timeout_hit_c) begin
          code_d = ERR_TIMEOUT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_EXEC: begin
        if (exec_done && redirect_valid) begin
          if (misaligned_c) code_d = ERR_MISALIGN;
          else              pc_d   = redirect_pc;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= PC_RESET;
      cnt_q        <= '0;
      wait_q       <= '0;
      code_q       <= 2'b00;
      exec_start_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      code_q       <= code_d;
      exec_start_q <= exec_start_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign ir_ena      = (state_q == S_FETCH) && imem_ready;
  assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign err         = (state_q == S_ERR);
  assign err_code    = code_q;
  assign pc_out      = pc_q;
  assign imem_addr   = pc_q;
  assign exec_start  = exec_start_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;

  localparam logic [31:0] PC0 = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        ir_ena;
  logic [31:0] pc_out;
  logic        exec_start;
  logic        exec_done;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] instr_count;

  int n_vec = 0;
  int n_err = 0;

  ifetch_ctrl #(.PC_RESET(PC0), .TIMEOUT(16'd4)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .ir_ena(ir_ena), .pc_out(pc_out), .exec_start(exec_start),
    .exec_done(exec_done), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy), .err(err),
    .err_code(err_code), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, then let combinational outputs settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; exec_done = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    rst = 1'b0;
    #1;
    check("rst_pc",    pc_out,      PC0);
    check("rst_addr",  imem_addr,   PC0);
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_irena", 32'(ir_ena),   32'd0);
    check("rst_start", 32'(exec_start), 32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_err",   32'(err),      32'd0);
    check("rst_code",  32'(err_code), 32'd0);
    check("rst_cnt",   instr_count,   32'd0);

    // Back-to-back: ready and done held high, 2 cycles per instruction
    @(negedge clk);
    run = 1'b1; imem_ready = 1'b1; exec_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("b2b_req",   32'(imem_req), 32'd1);
      check("b2b_addr",  imem_addr,     PC0 + 32'(4 * i));
      check("b2b_irena", 32'(ir_ena),   32'd1);
      step();
      check("b2b_start", 32'(exec_start), 32'd1);
      check("b2b_irena_exec", 32'(ir_ena), 32'd0);
      check("b2b_pc4",   pc_out,        PC0 + 32'(4 * i + 4));
      check("b2b_cnt",   instr_count,   32'(i + 1));
    end

    // Three wait states, ready in the 4th cycle (also the no-timeout case)
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) imem_ready = 1'b1;
      #1;
      check("ws_req",   32'(imem_req), 32'd1);
      check("ws_addr",  imem_addr,     32'h0040_000C);
      check("ws_irena", 32'(ir_ena),   (k == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
    #1;
    check("ws_start", 32'(exec_start), 32'd1);
    check("ws_err",   32'(err),        32'd0);
    check("ws_cnt",   instr_count,     32'd4);

    // Aligned redirect: next fetch at target, no idle cycle
    step();
    redirect_valid = 1'b0;
    check("rd_req",  32'(imem_req), 32'd1);
    check("rd_addr", imem_addr,     32'h0040_0100);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0102;
    #1;
    check("rd_pc4", pc_out, 32'h0040_0104);

    // Misaligned redirect -> sticky fault, pc unchanged
    step();
    redirect_valid = 1'b0;
    check("mis_err",  32'(err),      32'd1);
    check("mis_code", 32'(err_code), 32'd2);
    check("mis_pc",   pc_out,        32'h0040_0104);
    check("mis_busy", 32'(busy),     32'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      check("mis_req_hold", 32'(imem_req), 32'd0);
    end
    check("mis_cnt_frozen", instr_count, 32'd5);
    check("mis_pc_frozen",  pc_out,      32'h0040_0104);
    rst = 1'b1;
    #1;
    check("mis_rst_err",  32'(err),      32'd0);
    check("mis_rst_code", 32'(err_code), 32'd0);
    check("mis_rst_pc",   pc_out,        PC0);

    // Timeout: ready never asserted, fault after exactly 4 FETCH cycles
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0; run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("to_req", 32'(imem_req), 32'd1);
      check("to_err", 32'(err),      32'd0);
    end
    step();
    check("to_err_set", 32'(err),      32'd1);
    check("to_code",    32'(err_code), 32'd1);
    check("to_req_off", 32'(imem_req), 32'd0);
    check("to_pc",      pc_out,        PC0);
    check("to_cnt",     instr_count,   32'd0);
    rst = 1'b1;

    // run dropped during a FETCH wait: fetch and EXEC complete, then IDLE
    @(negedge clk);
    rst = 1'b0; exec_done = 1'b0;
    step();
    run = 1'b0;
    check("rd_fetch_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    imem_ready = 1'b1;
    #1;
    check("rd_fetch_irena", 32'(ir_ena), 32'd1);
    step();
    check("rd_exec_start", 32'(exec_start), 32'd1);
    step();
    exec_done = 1'b1;
    check("rd_exec_wait_start", 32'(exec_start), 32'd0);
    check("rd_exec_wait_busy",  32'(busy),       32'd1);
    step();
    check("rd_idle_busy", 32'(busy),     32'd0);
    check("rd_idle_req",  32'(imem_req), 32'd0);
    check("rd_idle_pc",   pc_out,        32'h0040_0004);
    check("rd_idle_cnt",  instr_count,   32'd1);
    step();
    check("rd_idle_req2", 32'(imem_req), 32'd0);

    // rst mid-EXEC clears immediately, without a clock edge
    run = 1'b1; exec_done = 1'b0;
    step();
    check("me_req", 32'(imem_req), 32'd1);
    step();
    check("me_busy", 32'(busy),    32'd1);
    check("me_pc",   pc_out,       32'h0040_0008);
    check("me_cnt",  instr_count,  32'd2);
    #1;
    rst = 1'b1;
    #1;
    check("me_rst_pc",    pc_out,           PC0);
    check("me_rst_cnt",   instr_count,      32'd0);
    check("me_rst_busy",  32'(busy),        32'd0);
    check("me_rst_start", 32'(exec_start),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
